// File: rtl/lsu_data_memory.sv
// rtl/lsu_data_memory.sv - RV32I handshaked byte-lane data memory (optional LSU_MEM_ALIGN_CHECK_EN)
module lsu_data_memory #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH:0] SPAN = (DATA_WIDTH+1)'(4 * DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state;
    logic [2:0]            ld_funct3;
    logic [1:0]            ld_off;
    logic [DATA_WIDTH-1:0] rel_addr;
    logic [AW-1:0]         word_idx;
    logic [1:0]            raw_off;
    logic [1:0]            eff_off;
    logic                  is_half;
    logic                  is_word;
    logic                  range_err;
    logic                  funct3_err;
    logic                  align_err;
    logic                  req_err;
    logic [3:0]            lane_mask;
    logic [3:0]            lane_en;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_fmt;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    assign rel_addr  = req_addr - BASE_ADDR;
    assign word_idx  = rel_addr[AW+1:2];
    assign raw_off   = req_addr[1:0];
    assign is_half   = (req_funct3[1:0] == 2'b01);
    assign is_word   = (req_funct3[1:0] == 2'b10);
    assign range_err = (req_addr < BASE_ADDR) || ({1'b0, rel_addr} >= SPAN);

    // Decode request: legal funct3, alignment policy and effective lane offset
    always_comb begin
        funct3_err = 1'b0;
        if (req_we) begin
            funct3_err = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
        end else begin
            funct3_err = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
                           req_funct3 == 3'b100 || req_funct3 == 3'b101);
        end
`ifdef LSU_MEM_ALIGN_CHECK_EN
        align_err = (is_half && raw_off[0]) || (is_word && raw_off != 2'd0);
        eff_off   = raw_off;
`else
        // Misaligned accesses are forced back inside the word rather than faulting
        align_err = 1'b0;
        if (is_word) begin
            eff_off = 2'd0;
        end else if (is_half && raw_off == 2'd3) begin
            eff_off = 2'd2;
        end else begin
            eff_off = raw_off;
        end
`endif
        if (is_word) begin
            lane_mask = 4'b1111;
        end else if (is_half) begin
            lane_mask = 4'b0011;
        end else begin
            lane_mask = 4'b0001;
        end
    end

    assign req_err  = range_err || funct3_err || align_err;
    assign lane_en  = lane_mask << eff_off;
    assign wdata_sh = req_wdata << {eff_off, 3'b000};
    assign accept   = (state == S_IDLE) && req_valid;
    // rst_n gating keeps an edge that coincides with reset assertion from writing
    assign wr_en    = accept && req_we && !req_err && rst_n;
    assign rd_en    = accept && !req_we && !req_err;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        // Byte-lane RAM: write on the acceptance edge, synchronous read for loads
        always_ff @(posedge clk) begin
            if (wr_en && lane_en[l]) begin
                mem[word_idx] <= wdata_sh[8*l +: 8];
            end
            if (rd_en) begin
                rd_q <= mem[word_idx];
            end
        end

        assign rd_word[8*l +: 8] = rd_q;
    end

    assign shifted = rd_word >> {ld_off, 3'b000};

    // Extract and extend the addressed byte/halfword from the bank read word
    always_comb begin
        load_fmt = '0;
        case (ld_funct3)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_fmt = shifted;
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_fmt = '0;
        endcase
    end

    // Request/response FSM and response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ld_funct3  <= 3'b000;
            ld_off     <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ld_funct3  <= req_funct3;
                        ld_off     <= eff_off;
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        state      <= (req_err || req_we) ? S_RESP : S_READ;
                    end
                end
                S_READ: begin
                    resp_rdata <= load_fmt;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_data_memory.md
# lsu_data_memory

Parametrised, handshaked data memory for the RV32I load/store path. It has four 8-bit byte-lane banks with per-lane write enables generated internally from funct3 and the address offset. It performs sub-word store lane steering, load extraction with sign/zero extension, and range/alignment checking, returning one response per accepted request. It sits between the core's memory stage and the byte-lane RAM primitives and replaces direct bank control by the core.

## Interface
Parameters:
- DATA_WIDTH, 32, data/address bus width; only 32 is legal (RV32I).
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH_WORDS·4-aligned.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte/half in LSBs).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  access fault (range, funct3, or alignment when enabled).

## Operation
- FSM states are IDLE, READ, RESP.
- IDLE: req_ready=1. On req_valid, the request is accepted at the rising edge.
  - Error or store: go to RESP.
  - Valid load: go to READ.
- READ: the bank read data is valid. Capture the formatted load result into the response register, then go to RESP.
- RESP: resp_valid=1. Hold resp_rdata/resp_err stable until resp_ready=1, then return to IDLE. There is no back-to-back acceptance; req_ready is low in READ and RESP.
- Word index = (req_addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Offset = req_addr[1:0].
- Range error: req_addr < BASE_ADDR or req_addr ≥ BASE_ADDR + 4·DEPTH_WORDS.
- funct3 error: load funct3 ∉ {000,001,010,100,101}; store funct3 ∉ {000,001,010}.
- Store lane enables:
  - SB: lane[offset].
  - SH: lanes {offset, offset+1}.
  - SW: all four lanes.
- Store data steering: wdata byte k is written to lane offset+k.
- Loads read all four lanes, then select by offset.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: raw word.
- An erroring request never writes any bank and reports resp_err=1, resp_rdata=0.
- Memory contents are not initialised and not cleared by reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE.
- Store and error latency: resp_valid is high in the cycle after acceptance (1 cycle).
- Load latency: resp_valid is high 2 cycles after acceptance.
- The bank write occurs on the acceptance edge only, so a store is atomic. A load issued after a store response observes the stored data.
- resp_ready held high: throughput is one store per 2 cycles and one load per 3 cycles.
- resp_ready low in RESP: all outputs are held; req_ready stays 0; req_valid is ignored.
- Reset asserted mid-operation: returns to IDLE immediately and drops the response. A store accepted before reset remains written. An edge coincident with reset assertion writes nothing.

## Configuration
- LSU_MEM_ALIGN_CHECK_EN defined:
  - LH/LHU/SH with offset[0]=1 report resp_err=1.
  - LW/SW with offset≠0 report resp_err=1.
  - No write occurs on these errors.
- Not defined:
  - LW/SW ignore offset and use lanes 0–3 (force-aligned).
  - Halfword accesses with offset=3 are forced to offset 2.
  - No alignment error is ever raised.

## Test plan
- Reset → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- SW 0xDEADBEEF @BASE+0x10, then LW, LB, LBU at +0x13, and LH at +0x12 → responses 0xDEADBEEF, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD; store latency 1, load latency 2.
- SW 0x00000000 @+0x20, SB 0xA5 @+0x21, SH 0x1234 @+0x22, then LW @+0x20 → 0x1234A500; the untouched lane stays 0x00.
- SW @BASE+4·DEPTH_WORDS → resp_err=1 after 1 cycle; a subsequent LW at the last valid word is unchanged. Load funct3=011 → resp_err=1.
- Hold resp_ready=0 for 5 cycles after an LW → resp_valid and resp_rdata stable; req_ready=0; a new req_valid is not accepted until the cycle after the handshake.
- With LSU_MEM_ALIGN_CHECK_EN, SW @+0x31 → resp_err=1 and memory is unchanged. Without it, the same store writes word +0x30 and a following LW @+0x30 returns the stored data.
